// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute/memory/writeback,
// owns NZCV flags and the condition check, stalls on mem_ready, counts retired instructions.
module multicycle_control_unit #(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           cond,
    input  logic [1:0]           op,
    input  logic [5:0]           funct,
    input  logic [3:0]           rd,
    input  logic [3:0]           alu_flags,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 adr_src,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           imm_src,
    output logic [1:0]           reg_src,
    output logic [3:0]           flags,
    output logic [CNT_W-1:0]     instr_count
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);

    state_t state, next_state, out_state;

    logic [3:0]           cmd;
    logic                 s_bit, i_bit, u_bit, l_bit;
    logic                 cmd_ok, is_cmp, cv_upd;
    logic [ALUCTRL_W-1:0] dp_alu;
    logic                 cond_ex;
    logic                 n_f, z_f, c_f, v_f;
    logic                 flag_upd, retire;

    assign cmd   = funct[4:1];
    assign s_bit = funct[0];
    assign i_bit = funct[5];
    assign u_bit = funct[3];
    assign l_bit = funct[0];
    assign {n_f, z_f, c_f, v_f} = flags;

    assign imm_src = op;
    assign reg_src = {op == 2'b01, op == 2'b10};

    always_comb begin
        cmd_ok = 1'b1;
        is_cmp = 1'b0;
        cv_upd = 1'b0;
        dp_alu = ALU_ADD;
        case (cmd)
            4'b0100: begin dp_alu = ALU_ADD; cv_upd = 1'b1; end
            4'b0010: begin dp_alu = ALU_SUB; cv_upd = 1'b1; end
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            4'b1010: begin dp_alu = ALU_SUB; cv_upd = 1'b1; is_cmp = 1'b1; end
            default: cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !c_f || z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = z_f || (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // While reset is high the outputs present the FETCH decode with all strobes off.
    assign out_state = reset ? S_FETCH : state;

    always_comb begin
        next_state  = out_state;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        flag_upd    = 1'b0;
        retire      = 1'b0;
        case (out_state)
            S_FETCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (!cond_ex || op == 2'b11) next_state = S_FETCH;
                else if (op == 2'b01)        next_state = S_MEMADR;
                else if (op == 2'b10)        next_state = S_BRANCH;
                else                         next_state = i_bit ? S_EXECI : S_EXECR;
            end
            S_MEMADR: begin
                alu_src_b   = 2'b01;
                alu_control = u_bit ? ALU_ADD : ALU_SUB;
                next_state  = l_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                pc_write   = (rd == 4'd15);
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (out_state == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = cmd_ok ? dp_alu : ALU_ADD;
                flag_upd    = cmd_ok && (s_bit || is_cmp);
                retire      = cmd_ok && is_cmp;
                next_state  = (cmd_ok && !is_cmp) ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                pc_write   = (rd == 4'd15);
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    // Logical ops refresh only N and Z; C and V keep their previous values.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags       <= 4'b0000;
            instr_count <= '0;
        end else begin
            if (flag_upd) begin
                flags[3:2] <= alu_flags[3:2];
                if (cv_upd) flags[1:0] <= alu_flags[1:0];
            end
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule
